// File: rtl/obuf_tctrl_seq.sv
// Tristate sequencer for a bidirectional DDR pad group: preamble, data beats,
// postamble and a hi-Z turnaround guard, with the receiver gated off while driving.
module obuf_tctrl_seq #(
   parameter int    PREAMBLE        = 1,
   parameter int    POSTAMBLE       = 1,
   parameter int    GUARD           = 2,
   parameter int    BURST_W         = 4,
   parameter string USE_IBUFDISABLE = "TRUE"
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_req,
   input  logic [BURST_W-1:0] wr_len,
   output logic               wr_ack,
   output logic               busy,
   output logic               preamble,
   output logic               data_valid,
   output logic               t_out,
   output logic               ibufdisable,
   output logic               intermdisable
);

   localparam int CW = (BURST_W > 3) ? BURST_W : 3;
   localparam logic IBUF_EN = (USE_IBUFDISABLE == "TRUE");
   localparam logic [CW-1:0] PRE_LD  = CW'(PREAMBLE - 1);
   localparam logic [CW-1:0] POST_LD = CW'(POSTAMBLE - 1);
   localparam logic [CW-1:0] GRD_LD  = CW'(GUARD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_POST,
      S_GUARD
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BURST_W-1:0] len_q, len_d;
   logic               ack_d;
   logic               drive_d;

   // Each state owns the down-counter from entry; the state advances when it hits 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ack_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_req) begin
               state_d = S_PRE;
               cnt_d   = PRE_LD;
               len_d   = wr_len;
               ack_d   = 1'b1;
            end
         end
         S_PRE: begin
            if (cnt_q == '0) begin
               state_d = S_DATA;
               cnt_d   = CW'(len_q);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (wr_req) begin
               // Back-to-back burst: keep driving, no pre/postamble in between.
               cnt_d = CW'(wr_len);
               len_d = wr_len;
               ack_d = 1'b1;
            end else if (POSTAMBLE != 0) begin
               state_d = S_POST;
               cnt_d   = POST_LD;
            end else if (GUARD != 0) begin
               state_d = S_GUARD;
               cnt_d   = GRD_LD;
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_POST, S_GUARD: begin
            if (wr_req) begin
               state_d = S_PRE;
               cnt_d   = PRE_LD;
               len_d   = wr_len;
               ack_d   = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (state_q == S_POST && GUARD != 0) begin
               state_d = S_GUARD;
               cnt_d   = GRD_LD;
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      drive_d = (state_d == S_PRE) || (state_d == S_DATA) || (state_d == S_POST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         len_q         <= '0;
         wr_ack        <= 1'b0;
         busy          <= 1'b0;
         preamble      <= 1'b0;
         data_valid    <= 1'b0;
         t_out         <= 1'b1;
         ibufdisable   <= 1'b0;
         intermdisable <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         wr_ack        <= ack_d;
         busy          <= (state_d != S_IDLE);
         preamble      <= (state_d == S_PRE);
         data_valid    <= (state_d == S_DATA);
         t_out         <= ~drive_d;
         ibufdisable   <= IBUF_EN && (state_d != S_IDLE);
         intermdisable <= drive_d;
      end
   end

endmodule

// File: tb/tb_obuf_tctrl_seq.sv
// Bench for obuf_tctrl_seq: default instance plus a PREAMBLE=3 / no post / no guard /
// no ibufdisable instance, both checked every cycle against a timeline model.
module tb_obuf_tctrl_seq;

   localparam int IDL = 0, PRE = 1, DAT = 2, PST = 3, GRD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req [2];
   logic [3:0] len [2];
   logic       ack [2], bsy [2], pre [2], dv [2], tq [2], ib [2], it [2];

   int total = 0;
   int bad = 0;

   // Model: a list of phases scheduled for the coming cycles, rebuilt on each accept.
   int pre_p [2] = '{1, 3};
   int post_p[2] = '{1, 0};
   int grd_p [2] = '{2, 0};
   bit ibuf_p[2] = '{1'b1, 1'b0};
   int tl [2][64];
   int tl_n [2] = '{0, 0};
   int tl_pos [2] = '{0, 0};
   int cur [2] = '{IDL, IDL};
   bit eack [2] = '{1'b0, 1'b0};

   bit rnd_en = 1'b0;
   int n_dv0 = 0, n_ack0 = 0, n_pre1 = 0;
   int any_ib1 = 0;

   always #5 clk = ~clk;

   obuf_tctrl_seq u_dut0 (
      .clk(clk), .rst(rst), .wr_req(req[0]), .wr_len(len[0]), .wr_ack(ack[0]),
      .busy(bsy[0]), .preamble(pre[0]), .data_valid(dv[0]), .t_out(tq[0]),
      .ibufdisable(ib[0]), .intermdisable(it[0])
   );

   obuf_tctrl_seq #(
      .PREAMBLE(3), .POSTAMBLE(0), .GUARD(0), .BURST_W(4), .USE_IBUFDISABLE("FALSE")
   ) u_dut1 (
      .clk(clk), .rst(rst), .wr_req(req[1]), .wr_len(len[1]), .wr_ack(ack[1]),
      .busy(bsy[1]), .preamble(pre[1]), .data_valid(dv[1]), .t_out(tq[1]),
      .ibufdisable(ib[1]), .intermdisable(it[1])
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input int i, input int ph);
      tl[i][tl_n[i]] = ph;
      tl_n[i]++;
   endtask

   task automatic model_edge(input int i, input bit r, input int l, input bit rstv);
      int nxt;
      bit acc;
      if (rstv) begin
         cur[i] = IDL; tl_n[i] = 0; tl_pos[i] = 0; eack[i] = 1'b0;
         return;
      end
      nxt = (tl_pos[i] < tl_n[i]) ? tl[i][tl_pos[i]] : IDL;
      acc = r && (cur[i] == IDL || cur[i] == PST || cur[i] == GRD ||
                  (cur[i] == DAT && nxt != DAT));
      if (acc) begin
         tl_n[i] = 0;
         tl_pos[i] = 0;
         if (cur[i] != DAT) repeat (pre_p[i]) push(i, PRE);
         repeat (l + 1) push(i, DAT);
         repeat (post_p[i]) push(i, PST);
         repeat (grd_p[i]) push(i, GRD);
      end
      eack[i] = acc;
      if (tl_pos[i] < tl_n[i]) begin
         cur[i] = tl[i][tl_pos[i]];
         tl_pos[i]++;
      end else begin
         cur[i] = IDL;
      end
   endtask

   function automatic logic [6:0] expv(input int i);
      bit drv, b;
      drv = (cur[i] == PRE) || (cur[i] == DAT) || (cur[i] == PST);
      b   = (cur[i] != IDL);
      return {eack[i], b, cur[i] == PRE, cur[i] == DAT, !drv, ibuf_p[i] && b, drv};
   endfunction

   function automatic logic [6:0] obsv(input int i);
      return {ack[i], bsy[i], pre[i], dv[i], tq[i], ib[i], it[i]};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge(0, req[0], int'(len[0]), rst);
      model_edge(1, req[1], int'(len[1]), rst);
      #1;
      chk("dut0_outs", int'(obsv(0)), int'(expv(0)));
      chk("dut1_outs", int'(obsv(1)), int'(expv(1)));
      if (dv[0]) n_dv0++;
      if (ack[0]) n_ack0++;
      if (pre[1]) n_pre1++;
      if (ib[1]) any_ib1++;
      if (rnd_en) begin
         for (int i = 0; i < 2; i++) begin
            if (req[i] && eack[i]) req[i] = 1'b0;
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               len[i] = 4'($urandom_range(0, 15));
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      req[0] = 1'b0; req[1] = 1'b0; len[0] = '0; len[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state0", int'(obsv(0)), 'h04);
      chk("rst_state1", int'(obsv(1)), 'h04);
      rst = 1'b0;

      // Single burst of 4 beats, then guard and idle.
      req[0] = 1'b1; len[0] = 4'd3;
      step();
      req[0] = 1'b0;
      repeat (9) step();

      // Back-to-back: new request in the last data beat.
      req[0] = 1'b1; len[0] = 4'd1;
      step();
      req[0] = 1'b0;
      repeat (2) step();
      req[0] = 1'b1; len[0] = 4'd0;
      step();
      req[0] = 1'b0;
      repeat (5) step();

      // Request arriving during guard.
      req[0] = 1'b1; len[0] = 4'd3;
      step();
      req[0] = 1'b0;
      repeat (6) step();
      req[0] = 1'b1; len[0] = 4'd2;
      step();
      req[0] = 1'b0;
      repeat (12) step();

      // Max length burst with ignored pulses in PRE and mid-DATA.
      n_dv0 = 0; n_ack0 = 0;
      req[0] = 1'b1; len[0] = 4'd15;
      step();
      req[0] = 1'b1; len[0] = 4'd5;
      step();
      req[0] = 1'b0;
      repeat (3) step();
      req[0] = 1'b1;
      step();
      req[0] = 1'b0;
      repeat (20) step();
      chk("len15_beats", n_dv0, 16);
      chk("len15_acks", n_ack0, 1);

      // Second instance: 3-cycle preamble, straight back to idle.
      n_pre1 = 0;
      req[1] = 1'b1; len[1] = 4'd2;
      step();
      req[1] = 1'b0;
      repeat (8) step();
      chk("pre3_cycles", n_pre1, 3);

      // Asynchronous reset in the middle of a burst.
      req[0] = 1'b1; len[0] = 4'd7;
      step();
      req[0] = 1'b0;
      repeat (4) step();
      #3;
      rst = 1'b1;
      req[0] = 1'b1; len[0] = 4'd2;
      #1;
      chk("arst_tout", int'(tq[0]), 1);
      chk("arst_dv", int'(dv[0]), 0);
      chk("arst_busy", int'(bsy[0]), 0);
      model_edge(0, 1'b0, 0, 1'b1);
      model_edge(1, 1'b0, 0, 1'b1);
      step();
      #2;
      rst = 1'b0;
      step();
      chk("arst_reack", int'(ack[0]), 1);
      req[0] = 1'b0;
      repeat (8) step();

      // Randomised traffic on both instances.
      rnd_en = 1'b1;
      repeat (600) step();
      rnd_en = 1'b0;
      req[0] = 1'b0; req[1] = 1'b0;
      repeat (40) step();
      chk("ibuf1_never", any_ib1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
